// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I controller.
// Optional trap on unknown opcodes: ILLEGAL_TRAP_EN.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_LUI,
    S_ALU_WB,
    S_JALR_ADR,
    S_JUMP,
    S_BRANCH,
    S_TRAP
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_RS1   = 2'd2
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_PASSB = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'd0,
    RES_MEMDATA = 2'd1,
    RES_ALU     = 2'd2
  } result_src_t;

endpackage

// File: rtl/ctrl_next_state.sv
// Next-state and opcode decode for the multi-cycle controller.
// Unknown opcodes trap when ILLEGAL_TRAP_EN is defined.
module ctrl_next_state
  import multicycle_ctrl_pkg::*;
(
  input  ctrl_state_t state_i,
  input  logic [6:0]  op_i,
  input  logic        mem_ready_i,
  output ctrl_state_t state_o
);

  ctrl_state_t dec_d;

  always_comb begin
    dec_d = S_FETCH;
    unique case (op_i)
      OP_LOAD,
      OP_STORE:  dec_d = S_MEM_ADR;
      OP_OP:     dec_d = S_EXEC_R;
      OP_IMM:    dec_d = S_EXEC_I;
      OP_LUI:    dec_d = S_EXEC_LUI;
      OP_AUIPC:  dec_d = S_ALU_WB;
      OP_JAL:    dec_d = S_JUMP;
      OP_JALR:   dec_d = S_JALR_ADR;
      OP_BRANCH: dec_d = S_BRANCH;
      OP_FENCE,
      OP_SYSTEM: dec_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      default:   dec_d = S_TRAP;
`else
      default:   dec_d = S_FETCH;
`endif
    endcase
  end

  always_comb begin
    state_o = state_i;
    unique case (state_i)
      S_RESET:    state_o = S_FETCH;
      S_FETCH:    state_o = mem_ready_i ? S_DECODE
                                        : S_FETCH;
      S_DECODE:   state_o = dec_d;
      S_MEM_ADR:  state_o = (op_i == OP_STORE) ? S_MEM_WR
                                               : S_MEM_RD;
      S_MEM_RD:   state_o = mem_ready_i ? S_MEM_WB
                                        : S_MEM_RD;
      S_MEM_WB:   state_o = S_FETCH;
      S_MEM_WR:   state_o = mem_ready_i ? S_FETCH
                                        : S_MEM_WR;
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_LUI: state_o = S_ALU_WB;
      S_ALU_WB:   state_o = S_FETCH;
      S_JALR_ADR: state_o = S_JUMP;
      S_JUMP:     state_o = S_ALU_WB;
      S_BRANCH:   state_o = S_FETCH;
      S_TRAP:     state_o = S_TRAP;
      default:    state_o = S_RESET;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multi-cycle RV32I datapath.
// Define ILLEGAL_TRAP_EN to add the illegal output and TRAP state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [CNT_W-1:0] instret
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic retire;

  alu_src_a_t  a_sel;
  alu_src_b_t  b_sel;
  alu_op_t     aop;
  result_src_t rsel;
  logic        trap;

  ctrl_next_state u_ns (
    .state_i     (state_q),
    .op_i        (op),
    .mem_ready_i (mem_ready),
    .state_o     (state_d)
  );

  // Staying in FETCH while stalled is not a retirement.
  assign retire = (state_d == S_FETCH) &&
                  (state_q != S_FETCH) &&
                  (state_q != S_RESET);

  assign instret_d = retire ? instret_q + CNT_W'(1)
                            : instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    a_sel     = SRCA_PC;
    b_sel     = SRCB_RS2;
    aop       = ALU_ADD;
    rsel      = RES_ALUOUT;
    trap      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        b_sel    = SRCB_FOUR;
        rsel     = RES_ALU;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        a_sel = SRCA_OLDPC;
        b_sel = SRCB_IMM;
      end
      S_MEM_ADR,
      S_JALR_ADR: begin
        a_sel = SRCA_RS1;
        b_sel = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        rsel      = RES_MEMDATA;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXEC_R: begin
        a_sel = SRCA_RS1;
        aop   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        a_sel = SRCA_RS1;
        b_sel = SRCB_IMM;
        aop   = ALU_FUNCT;
      end
      S_EXEC_LUI: begin
        b_sel = SRCB_IMM;
        aop   = ALU_PASSB;
      end
      S_ALU_WB: reg_write = 1'b1;
      // PC takes the target from ALUOut while the ALU forms old_pc+4.
      S_JUMP: begin
        pc_write = 1'b1;
        a_sel    = SRCA_OLDPC;
        b_sel    = SRCB_FOUR;
      end
      S_BRANCH: begin
        a_sel    = SRCA_RS1;
        aop      = ALU_SUB;
        pc_write = branch_taken;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign alu_src_a  = a_sel;
  assign alu_src_b  = b_sel;
  assign alu_op     = aop;
  assign result_src = rsel;
  assign instret    = instret_q;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = trap;
`else
  logic unused_trap;
  assign unused_trap = trap;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard testbench for multicycle_ctrl.
// Covers both builds, with and without ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  localparam int B_RESET = 0, B_FETCH = 1, B_DECODE = 2;
  localparam int B_MADR = 3, B_MRD = 4, B_MWB = 5;
  localparam int B_MWR = 6, B_EXR = 7, B_EXI = 8;
  localparam int B_LUI = 9, B_AWB = 10, B_JADR = 11;
  localparam int B_JUMP = 12, B_BR = 13, B_TRAP = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       op;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req, mem_we, adr_src;
  logic             ir_write, pc_write, reg_write;
  logic [1:0]       alu_src_a, alu_src_b;
  logic [1:0]       alu_op, result_src;
  logic [CNT_W-1:0] instret;
  logic             illegal_w;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .adr_src      (adr_src),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .result_src   (result_src),
    .instret      (instret)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal      (illegal_w)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0]      exp;
    logic             mr;
    logic             br;
    logic [6:0]       op;
    logic [CNT_W-1:0] cnt;
    string            name;
  } item_t;

  item_t            sbq[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] count = '0;

  function automatic logic [14:0] pk(
    input logic il, mq, mw, ad, ir, pw, rw,
    input logic [1:0] a, b, ao, rs);
    return {il, mq, mw, ad, ir, pw, rw, a, b, ao, rs};
  endfunction

  function automatic logic [14:0] expv(
    input int st, input logic mr, input logic br);
    case (st)
      B_FETCH:  return pk(0,1,0,0,mr,mr,0,2'd0,2'd2,2'd0,2'd2);
      B_DECODE: return pk(0,0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0);
      B_MADR:   return pk(0,0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0);
      B_MRD:    return pk(0,1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0);
      B_MWB:    return pk(0,0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd1);
      B_MWR:    return pk(0,1,1,1,0,0,0,2'd0,2'd0,2'd0,2'd0);
      B_EXR:    return pk(0,0,0,0,0,0,0,2'd2,2'd0,2'd2,2'd0);
      B_EXI:    return pk(0,0,0,0,0,0,0,2'd2,2'd1,2'd2,2'd0);
      B_LUI:    return pk(0,0,0,0,0,0,0,2'd0,2'd1,2'd3,2'd0);
      B_AWB:    return pk(0,0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0);
      B_JADR:   return pk(0,0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0);
      B_JUMP:   return pk(0,0,0,0,0,1,0,2'd1,2'd2,2'd0,2'd0);
      B_BR:     return pk(0,0,0,0,0,br,0,2'd2,2'd0,2'd1,2'd0);
      B_TRAP:   return pk(1,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [14:0] got();
    return {illegal_w, mem_req, mem_we, adr_src, ir_write,
            pc_write, reg_write, alu_src_a, alu_src_b,
            alu_op, result_src};
  endfunction

  task automatic push(input int st, input logic mr,
                      input logic br, input logic [6:0] o,
                      input string nm);
    item_t it;
    it.exp  = expv(st, mr, br);
    it.mr   = mr;
    it.br   = br;
    it.op   = o;
    it.cnt  = count;
    it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic push_instr(input logic [6:0] o,
                            input logic br,
                            input int fw, input int mw,
                            input string nm);
    for (int i = 0; i < fw; i++) push(B_FETCH, 0, br, o, nm);
    push(B_FETCH, 1, br, o, nm);
    push(B_DECODE, 1'($urandom_range(0, 1)), br, o, nm);
    case (o)
      7'b0000011: begin
        push(B_MADR, 1, br, o, nm);
        for (int i = 0; i < mw; i++) push(B_MRD, 0, br, o, nm);
        push(B_MRD, 1, br, o, nm);
        push(B_MWB, 1'($urandom_range(0, 1)), br, o, nm);
      end
      7'b0100011: begin
        push(B_MADR, 1, br, o, nm);
        for (int i = 0; i < mw; i++) push(B_MWR, 0, br, o, nm);
        push(B_MWR, 1, br, o, nm);
      end
      7'b0110011: begin
        push(B_EXR, 1, br, o, nm);
        push(B_AWB, 1, br, o, nm);
      end
      7'b0010011: begin
        push(B_EXI, 1, br, o, nm);
        push(B_AWB, 1, br, o, nm);
      end
      7'b0110111: begin
        push(B_LUI, 1, br, o, nm);
        push(B_AWB, 1, br, o, nm);
      end
      7'b0010111: push(B_AWB, 1, br, o, nm);
      7'b1101111: begin
        push(B_JUMP, 1, br, o, nm);
        push(B_AWB, 1, br, o, nm);
      end
      7'b1100111: begin
        push(B_JADR, 1, br, o, nm);
        push(B_JUMP, 1, br, o, nm);
        push(B_AWB, 1, br, o, nm);
      end
      7'b1100011: push(B_BR, 1, br, o, nm);
      7'b0001111, 7'b1110011: ;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++)
          push(B_TRAP, 1'($urandom_range(0, 1)), br, o, nm);
        return;
`endif
      end
    endcase
    count = count + 1;
  endtask

  task automatic drain();
    item_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      @(negedge clk);
      op           = it.op;
      mem_ready    = it.mr;
      branch_taken = it.br;
      #1;
      checks++;
      if (got() !== it.exp) begin
        errors++;
        $display("FAIL %s outputs got %h exp %h",
                 it.name, got(), it.exp);
      end
      checks++;
      if (instret !== it.cnt) begin
        errors++;
        $display("FAIL %s instret got %0d exp %0d",
                 it.name, instret, it.cnt);
      end
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (got() !== 15'd0 || instret !== '0) begin
      errors++;
      $display("FAIL %s got %h/%0d exp 0/0",
               nm, got(), instret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    op = 7'b0010011;
    mem_ready = 1'b1;
    branch_taken = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_zero("reset_held");
    rst = 1'b0;
    #1 check_zero("reset_released");
    count = '0;
  endtask

  task automatic test_alu();
    push_instr(7'b0010011, 0, 0, 0, "addi");
    drain();
    push_instr(7'b0110011, 0, 0, 0, "r_type");
    push_instr(7'b0110111, 0, 0, 0, "lui");
    push_instr(7'b0010111, 0, 0, 0, "auipc");
    drain();
  endtask

  task automatic test_mem();
    push_instr(7'b0000011, 0, 0, 3, "lw_wait");
    drain();
    push_instr(7'b0100011, 0, 2, 2, "sw_wait");
    push_instr(7'b0000011, 0, 0, 0, "lw");
    push_instr(7'b0100011, 0, 0, 0, "sw");
    drain();
  endtask

  task automatic test_jumps();
    push_instr(7'b1101111, 0, 0, 0, "jal");
    push_instr(7'b1100111, 0, 0, 0, "jalr");
    drain();
  endtask

  task automatic test_branch();
    push_instr(7'b1100011, 1, 0, 0, "beq_taken");
    push_instr(7'b1100011, 0, 0, 0, "beq_not");
    drain();
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [8];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011,
            7'b1100011, 7'b0001111, 7'b1110011,
            7'b1100111, 7'b0010011};
    for (int i = 0; i < 24; i++)
      push_instr(ops[i % 8], 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2), $urandom_range(0, 2),
                 "b2b");
    drain();
  endtask

  task automatic test_illegal();
    push_instr(7'b1111111, 0, 0, 0, "illegal_op");
    drain();
  endtask

  task automatic test_reset_mid();
    push(B_FETCH, 1, 0, 7'b0000011, "mid_fetch");
    push(B_DECODE, 1, 0, 7'b0000011, "mid_decode");
    push(B_MADR, 1, 0, 7'b0000011, "mid_adr");
    push(B_MRD, 0, 0, 7'b0000011, "mid_mrd");
    drain();
    #1 rst = 1'b1;
    #1 check_zero("mid_reset_async");
    count = '0;
    @(negedge clk);
    #1 check_zero("mid_reset_edge");
    rst = 1'b0;
    #1 check_zero("mid_reset_release");
    push_instr(7'b0010011, 0, 1, 0, "after_reset");
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_jumps();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared multi-cycle RV32I datapath: PC, IR, one ALU, ALUOut register, register file, and a single unified memory port.
- Decodes the opcode latched in IR and steps each instruction through fetch/decode/execute/memory/writeback.
- Drives all datapath mux selects, write enables, and the memory request handshake.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instret (wraps modulo 2^CNT_W)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
op  in  7  opcode field instr[6:0] from IR
branch_taken  in  1  branch comparator result (funct3 already applied)
mem_ready  in  1  memory accepts/completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  request is a store
adr_src  out  1  memory address: 0=PC, 1=ALUOut
ir_write  out  1  latch memory read data into IR and PC into old_pc
pc_write  out  1  PC <= result bus
reg_write  out  1  regfile write rd <= result bus
alu_src_a  out  2  0=PC, 1=old_pc, 2=rs1
alu_src_b  out  2  0=rs2, 1=imm_ext, 2=const 4
alu_op  out  2  0=add, 1=sub, 2=funct-decoded, 3=pass B
result_src  out  2  0=ALUOut reg, 1=mem data reg, 2=ALU result direct
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset: asynchronous on rst high. State=RESET, instret=0. All outputs are 0 in RESET. RESET->FETCH unconditionally on the first clk edge after release. Reset in any state aborts the instruction; no partial writes complete after the reset edge.
- ALUOut latches the ALU result every cycle (datapath side). The controller relies on this.
- States and outputs (unlisted outputs = 0):
  - FETCH: mem_req, adr_src=0, a=0, b=2, alu_op=0, result_src=2. If mem_ready: ir_write=1, pc_write=1, ->DECODE. Else stay; mem_req held high.
  - DECODE: a=1, b=1, alu_op=0 (ALUOut<=old_pc+imm). Next state by op:
    - LOAD/STORE -> MEM_ADR
    - OP -> EXEC_R
    - OP_IMM -> EXEC_I
    - LUI -> EXEC_LUI
    - AUIPC -> ALU_WB
    - JAL -> JUMP
    - JALR -> JALR_ADR
    - BRANCH -> BRANCH
    - FENCE/SYSTEM -> FETCH (retire as NOP)
    - other -> see Optional Feature
  - MEM_ADR: a=2, b=1, alu_op=0. LOAD -> MEM_RD, STORE -> MEM_WR.
  - MEM_RD: mem_req, adr_src=1. Wait for mem_ready, then ->MEM_WB.
  - MEM_WB: reg_write, result_src=1. ->FETCH.
  - MEM_WR: mem_req, mem_we, adr_src=1. Wait for mem_ready, then ->FETCH.
  - EXEC_R: a=2, b=0, alu_op=2. ->ALU_WB.
  - EXEC_I: a=2, b=1, alu_op=2. ->ALU_WB.
  - EXEC_LUI: b=1, alu_op=3. ->ALU_WB.
  - ALU_WB: reg_write, result_src=0. ->FETCH.
  - JALR_ADR: a=2, b=1, alu_op=0. ->JUMP.
  - JUMP: pc_write, result_src=0 (target). a=1, b=2, alu_op=0 (ALUOut<=old_pc+4). ->ALU_WB.
  - BRANCH: a=2, b=0, alu_op=1, result_src=0, pc_write=branch_taken. ->FETCH.
- mem_req/mem_we/adr_src are stable while waiting for mem_ready; mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- instret increments by 1 on every transition into FETCH except RESET->FETCH.
- Latency, no wait states: load 5, store 4, R/I/LUI 4, AUIPC 3, JAL 4, JALR 5, branch 3 cycles.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: adds output illegal (1 bit, reset 0). An unknown opcode in DECODE -> TRAP state. TRAP: all other outputs 0, illegal=1, no retire, held until rst.
- Undefined: an unknown opcode behaves as FENCE (DECODE->FETCH, retires); illegal port absent.

Decomposition:
- Package types: OP_* opcode constants (add OP_FENCE, OP_SYSTEM), ctrl_state_t enum, alu_src_a_t, alu_src_b_t, alu_op_t, result_src_t enums.
- One sub-module ctrl_next_state: combinational next-state/opcode decode. Output decode and instret counter stay in multicycle_ctrl.

Test Plan:
- rst pulse mid-MEM_RD -> state RESET, all outputs 0, instret=0; next edge FETCH with mem_req=1.
- addi x1,x0,5 (op=0010011), mem_ready always 1 -> FETCH,DECODE,EXEC_I,ALU_WB; reg_write only in cycle 4; instret 0->1.
- lw with mem_ready low 3 cycles in MEM_RD -> mem_req/adr_src=1 stable 4 cycles; MEM_WB reg_write=1, result_src=1.
- beq with branch_taken=1 then =0 -> pc_write=1 then 0 in BRANCH; 3 cycles each; instret +2.
- jalr (op=1100111) -> JALR_ADR a=2,b=1; JUMP pc_write=1,result_src=0; ALU_WB reg_write=1; 5 cycles.
- op=7'b1111111 -> with ILLEGAL_TRAP_EN: illegal=1 held, instret frozen; without: returns to FETCH, instret +1.
